frame_fade_driver: RTL
======================

// Module: frame_fade_driver
// PURPOSE
//  Output stage downstream of the light-show pattern engine. Accepts full frames:
//   - 28-bit active-high segment image (4 SSD digits)
//   - 18-bit LED image (10 red + 8 green)
//  Drives the board's active-low SSD buses and active-high LEDs.
//  Optional PWM crossfade from the displayed frame to a newly accepted one, so
//  pattern transitions dissolve instead of snapping.
// PARAMETERS
//  PWM_BITS          4    PWM resolution; 2**PWM_BITS duty slots and fade levels
//  PWM_DIV           195  Clock cycles per PWM slot (>=1); ~16 kHz PWM at 50 MHz
//  STEP_PWM_PERIODS  100  Full PWM periods per fade level (>=1)
// PORTS
//  Clock       in   1   Onboard 50 MHz clock; all state on rising edge
//  ResetN      in   1   Asynchronous, active-low reset
//  FrameValid  in   1   Upstream offers FrameSeg/FrameLed/FadeEn this cycle
//  FrameReady  out  1   Block can accept a frame; transfer = FrameValid & FrameReady
//  FrameSeg    in   28  Segments, 1=lit; [27:21]=Disp3 ... [6:0]=Disp0, each GFEDCBA
//  FrameLed    in   18  [17:8]=red LEDs 9..0, [7:0]=green LEDs 7..0, 1=lit
//  FadeEn      in   1   1=crossfade to this frame, 0=show immediately; sampled at transfer
//  Busy        out  1   High while a crossfade is in progress
//  Disp3..0    out  7   SSD buses, GFEDCBA, active-low (0 = segment on)
//  LedRed      out  10  Red LEDs, active-high
//  LedGrn      out  8   Green LEDs, active-high
// BEHAVIOUR
//  - Internal 46-bit frames:
//      Cur  = frame on display
//      Nxt  = fade target
//  - FSM states IDLE, FADE; FrameReady = (state==IDLE); Busy = (state==FADE).
//  - Reset (async, ResetN=0):
//      - state=IDLE, Cur=Nxt=0, Level=0, counters=0
//      - Disp3..0=7'h7F, LedRed=0, LedGrn=0
//      - FrameReady=1, Busy=0
//  - IDLE, transfer with FadeEn=0: Cur<=frame; stay IDLE.
//  - IDLE, transfer with FadeEn=1:
//      - Nxt<=frame; Level, PWM slot counter, divider, step counter all cleared
//      - go FADE
//  - FADE timing:
//      - Divider counts 0..PWM_DIV-1; on wrap, PwmCnt++ (mod 2**PWM_BITS)
//      - On each PwmCnt wrap (end of a full PWM period), step counter++
//      - When the step counter reaches STEP_PWM_PERIODS, it clears and Level++
//  - Fade end: at the step boundary where Level==2**PWM_BITS-1: Cur<=Nxt, Level=0, go IDLE.
//    Fade length = 2**PWM_BITS * STEP_PWM_PERIODS * 2**PWM_BITS * PWM_DIV cycles.
//  - Pixel image:
//      - IDLE: Cur
//      - FADE, bit equal in Cur/Nxt: that value, steady (no flicker)
//      - FADE, differing bit: Nxt if PwmCnt < Level, else Cur
//      - Level 0 = pure Cur
//  - Outputs are registered from the pixel image, so a capture is visible 1 cycle after the capture edge:
//      - Disp3=~img[27:21] ... Disp0=~img[6:0]
//      - LedRed=img[17:8], LedGrn=img[7:0]
//  - FrameValid while FADE is not accepted; upstream holds data until FrameReady. No queueing, no abort.
//  - FadeEn=1 with frame identical to Cur: full fade still runs (Busy for full length), outputs steady.
//  - FrameValid with X data while FrameReady=0 has no effect.
//  - ResetN asserted mid-fade: immediate blank and IDLE; no partial commit of Nxt.
// TESTING (bench params: PWM_BITS=2, PWM_DIV=2, STEP_PWM_PERIODS=1 -> fade = 32 cycles)
//  1 Assert ResetN=0 mid-clock -> Disp*=7'h7F, LedRed=0, LedGrn=0, FrameReady=1, Busy=0 without a clock edge.
//  2 IDLE; FrameValid=1, FadeEn=0, FrameSeg=28'h0000001, FrameLed=18'h3FFFF
//      -> next cycle Disp0=7'h7E, Disp3..1=7'h7F, LedRed=10'h3FF, LedGrn=8'hFF.
//  3 From test 2 display; FadeEn=1 with FrameSeg=28'h0000002, FrameLed=0
//      -> Busy=1 for exactly 32 cycles.
//      -> Disp0 bit1 low for L of 4 slots at level L=0..3.
//      -> then Disp0=7'h7D, LEDs 0, FrameReady=1.
//  4 Offer FrameValid=1 with new data every cycle during a fade
//      -> FrameReady=0 throughout; data not captured.
//      -> first accept occurs the cycle FrameReady returns to 1.
//  5 Fade where Cur/Nxt share FrameLed=18'h00F0F
//      -> LedGrn=8'h0F and LedRed bits 9..4 stay constant on every cycle of the fade.
//  6 Pulse ResetN low at cycle 10 of a fade -> outputs blank, Busy=0.
//      -> after release, FadeEn=0 load shows new frame 1 cycle later.

Source files
------------

// File: rtl/frame_fade_driver_if.sv
// rtl/frame_fade_driver_if.sv - frame handshake bundle from the pattern engine into the fade driver
interface frame_fade_driver_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [27:0] frame_seg;
  logic [17:0] frame_led;
  logic        fade_en;

  modport master (
    output frame_valid,
    output frame_seg,
    output frame_led,
    output fade_en,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_seg,
    input  frame_led,
    input  fade_en,
    output frame_ready
  );
endinterface

// File: rtl/frame_fade_driver.sv
// rtl/frame_fade_driver.sv - SSD/LED output stage with optional PWM crossfade between frames
module frame_fade_driver #(
  parameter int PWM_BITS         = 4,
  parameter int PWM_DIV          = 195,
  parameter int STEP_PWM_PERIODS = 100
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  frame_fade_driver_if.slave  frame_if,
  output logic                busy_o,
  output logic [6:0]          disp3_o,
  output logic [6:0]          disp2_o,
  output logic [6:0]          disp1_o,
  output logic [6:0]          disp0_o,
  output logic [9:0]          led_red_o,
  output logic [7:0]          led_grn_o
);

  localparam int DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int STEP_W = (STEP_PWM_PERIODS > 1) ? $clog2(STEP_PWM_PERIODS) : 1;

  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(PWM_DIV - 1);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PWM_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

  typedef enum logic {
    IDLE,
    FADE
  } state_t;

  state_t              state_q, state_d;
  logic [45:0]         cur_q, cur_d;
  logic [45:0]         nxt_q, nxt_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [45:0]         img;
  logic [45:0]         img_q;
  logic [45:0]         frame;
  logic                transfer;

  assign frame    = {frame_if.frame_seg, frame_if.frame_led};
  assign transfer = frame_if.frame_valid && (state_q == IDLE);

  assign frame_if.frame_ready = (state_q == IDLE);
  assign busy_o               = (state_q == FADE);

  // State and frame registers; reset blanks everything and drops any pending fade target
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cur_q   <= '0;
      nxt_q   <= '0;
      level_q <= '0;
      pwm_q   <= '0;
      div_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      level_q <= level_d;
      pwm_q   <= pwm_d;
      div_q   <= div_d;
      step_q  <= step_d;
    end
  end

  // Next-state: frame acceptance in IDLE, divider/slot/step/level cascade in FADE
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    level_d = level_q;
    pwm_d   = pwm_q;
    div_d   = div_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          if (frame_if.fade_en) begin
            nxt_d   = frame;
            level_d = '0;
            pwm_d   = '0;
            div_d   = '0;
            step_d  = '0;
            state_d = FADE;
          end else begin
            cur_d = frame;
          end
        end
      end
      FADE: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          pwm_d = pwm_q + 1'b1;
          if (pwm_q == PWM_MAX) begin
            if (step_q == STEP_LAST) begin
              step_d = '0;
              if (level_q == PWM_MAX) begin
                cur_d   = nxt_q;
                level_d = '0;
                state_d = IDLE;
              end else begin
                level_d = level_q + 1'b1;
              end
            end else begin
              step_d = step_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel image: bits equal in both frames come out the same either way, so only differing bits flicker
  always_comb begin
    img = cur_q;
    if ((state_q == FADE) && (pwm_q < level_q)) begin
      img = nxt_q;
    end
  end

  // Output register; zero image means all segments and LEDs dark
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      img_q <= '0;
    end else begin
      img_q <= img;
    end
  end

  assign disp3_o   = ~img_q[45:39];
  assign disp2_o   = ~img_q[38:32];
  assign disp1_o   = ~img_q[31:25];
  assign disp0_o   = ~img_q[24:18];
  assign led_red_o = img_q[17:8];
  assign led_grn_o = img_q[7:0];

endmodule
